// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types for the data memory arbiter (datapath widths, FSM states, port select, lock counter width)
package dmem_arbiter_pkg;
  typedef logic [31:0] DataPath;
  typedef logic [31:0] DataAddrPath;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} ArbState;
  typedef enum logic {ARB_PORT0, ARB_PORT1} ArbPortSel;
  localparam int ARB_LOCK_CNT_WIDTH = 8;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational winner select for the data memory arbiter
// Ports: req0/req1 requests, rr_ptr round-robin pointer, state arbiter FSM state, gnt one-hot grant vector {port1, port0}
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       req0,
  input  logic       req1,
  input  ArbPortSel  rr_ptr,
  input  ArbState    state,
  output logic [1:0] gnt
);
  logic w_win1;
  // Port 1 wins alone, or on a tie when round-robin points at it
  assign w_win1 = req1 & (!req0 | (PRIORITY_MODE == 0 && rr_ptr == ARB_PORT1));
  assign gnt = state == OWN0 ? {1'b0, req0} :
               state == OWN1 ? {req1, 1'b0} :
               {w_win1, req0 & !w_win1};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-beat data memory between two requesters with optional bounded lock
// Ports: clk, rst (async, active-low); per port reqN/weN/addrN/wdataN/lockN in, gntN/rvalidN/rdataN out;
//        memAddr/memDataIn/memWrEnable to memory, memDataOut from memory; lockTimeout pulses on forced release
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int PRIORITY_MODE   = 0,
  parameter int MAX_LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  DataAddrPath addr0,
  input  DataAddrPath addr1,
  input  DataPath     wdata0,
  input  DataPath     wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output DataPath     rdata0,
  output DataPath     rdata1,
  output DataAddrPath memAddr,
  output DataPath     memDataIn,
  output logic        memWrEnable,
  input  DataPath     memDataOut,
  output logic        lockTimeout
);
  localparam logic [ARB_LOCK_CNT_WIDTH-1:0] LOCK_MAX = ARB_LOCK_CNT_WIDTH'(MAX_LOCK_CYCLES);
  ArbState                       r_state;
  ArbPortSel                     r_rr_ptr;
  logic [ARB_LOCK_CNT_WIDTH-1:0] r_lock_cnt;
  logic [1:0]                    r_rvalid;
  logic                          r_lock_timeout;
  logic [1:0]                    w_pick;
  logic [1:0]                    w_gnt;
  logic                          w_forced;
  logic                          w_lock;
  logic                          w_own_lock;
  dmem_arb_pick #(.PRIORITY_MODE(PRIORITY_MODE)) u_pick (
    .req0   (req0),
    .req1   (req1),
    .rr_ptr (r_rr_ptr),
    .state  (r_state),
    .gnt    (w_pick)
  );
  // The forced-release cycle grants nothing so the owner cannot sneak one more access in
  assign w_forced    = r_state != IDLE && r_lock_cnt == LOCK_MAX;
  assign w_gnt       = (rst && !w_forced) ? w_pick : 2'b00;
  assign gnt0        = w_gnt[0];
  assign gnt1        = w_gnt[1];
  assign w_lock      = w_gnt[1] ? lock1 : lock0;
  assign w_own_lock  = r_state == OWN1 ? lock1 : lock0;
  assign memAddr     = w_gnt[1] ? addr1 : w_gnt[0] ? addr0 : '0;
  assign memDataIn   = w_gnt[1] ? wdata1 : w_gnt[0] ? wdata0 : '0;
  assign memWrEnable = w_gnt[1] ? we1 : w_gnt[0] ? we0 : 1'b0;
  assign rvalid0     = r_rvalid[0];
  assign rvalid1     = r_rvalid[1];
  assign rdata0      = memDataOut;
  assign rdata1      = memDataOut;
  assign lockTimeout = r_lock_timeout;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_rr_ptr       <= ARB_PORT0;
      r_lock_cnt     <= '0;
      r_rvalid       <= 2'b00;
      r_lock_timeout <= 1'b0;
    end else begin
      r_rvalid       <= {w_gnt[1] & req1 & !we1, w_gnt[0] & req0 & !we0};
      r_lock_timeout <= w_forced;
      if (w_forced) begin
        r_state    <= IDLE;
        r_lock_cnt <= '0;
        r_rr_ptr   <= r_state == OWN0 ? ARB_PORT1 : ARB_PORT0;
      end else if (|w_gnt) begin
        r_rr_ptr   <= w_gnt[0] ? ARB_PORT1 : ARB_PORT0;
        r_state    <= w_lock ? (w_gnt[0] ? OWN0 : OWN1) : IDLE;
        r_lock_cnt <= w_lock ? r_lock_cnt + 8'd1 : '0;
      end else if (r_state != IDLE) begin
        // Owner idles: a held lock keeps ownership and still counts toward the timeout
        r_state    <= w_own_lock ? r_state : IDLE;
        r_lock_cnt <= w_own_lock ? r_lock_cnt + 8'd1 : '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a registered memory model
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, memWrEnable, lockTimeout;
  logic [31:0] rdata0, rdata1, memAddr, memDataIn, mem_q;
  logic        fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_we, fp_lto;
  logic [31:0] fp_rdata0, fp_rdata1, fp_addr, fp_din;
  logic [31:0] mem [0:255];
  typedef struct {logic port; logic [31:0] data;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.PRIORITY_MODE(0), .MAX_LOCK_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .memAddr(memAddr), .memDataIn(memDataIn), .memWrEnable(memWrEnable),
    .memDataOut(mem_q), .lockTimeout(lockTimeout)
  );

  dmem_arbiter #(.PRIORITY_MODE(1), .MAX_LOCK_CYCLES(16)) dut_fp (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(fp_gnt0), .gnt1(fp_gnt1),
    .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
    .memAddr(fp_addr), .memDataIn(fp_din), .memWrEnable(fp_we),
    .memDataOut(mem_q), .lockTimeout(fp_lto)
  );

  // Registered memory: word index = byte address / 4, read data one cycle after the access
  always @(posedge clk) begin
    if (!rst) begin
      mem[16] <= 32'hDEADBEEF;
      mem[2]  <= 32'd5;
    end else if (memWrEnable) begin
      mem[memAddr[9:2]] <= memDataIn;
    end
    mem_q <= mem[memAddr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      chk("rv_exclusive", {31'd0, rvalid0 & rvalid1}, 32'd0);
      if (q.size() == 0) chk("rv_unexpected", {30'd0, rvalid1, rvalid0}, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rv_port", {31'd0, rvalid1}, {31'd0, e.port});
        chk("rv_data", rvalid1 ? rdata1 : rdata0, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; lock0 = 0; lock1 = 0;
    addr0 = 32'h80; addr1 = 32'h84; wdata0 = 0; wdata1 = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_we", memWrEnable, 0);
    chk("rst_lto", lockTimeout, 0);
    chk("rst_rvalid0", rvalid0, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt0", gnt0, (i % 2 == 0));
      chk("rr_gnt1", gnt1, (i % 2 == 1));
      chk("rr_addr", memAddr, (i % 2 == 0) ? 32'h80 : 32'h84);
      chk("rr_we", memWrEnable, 1);
      chk("fp_gnt0", fp_gnt0, 1);
      chk("fp_gnt1", fp_gnt1, 0);
      tick();
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("idle_gnt", {gnt1, gnt0}, 0);
    chk("idle_addr", memAddr, 0);
    chk("idle_din", memDataIn, 0);
    chk("idle_we", memWrEnable, 0);
    tick();
    req1 = 1; we1 = 0; addr1 = 32'h40;
    push(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_gnt1", gnt1, 1);
    chk("rd_gnt0", gnt0, 0);
    tick();
    req1 = 0;
    @(negedge clk);
    chk("rd_rvalid0", rvalid0, 0);
    tick();
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt0", gnt0, 1);
    chk("wr_din", memDataIn, 32'h12345678);
    tick();
    req0 = 0; req1 = 1; we1 = 0; addr1 = 32'h20;
    push(1, 32'h12345678);
    @(negedge clk);
    chk("rb_gnt1", gnt1, 1);
    tick();
    req1 = 0;
    tick();
    req0 = 1; we0 = 0; addr0 = 32'h8; lock0 = 1;
    req1 = 1; we1 = 0; addr1 = 32'h40;
    push(0, 32'd5);
    push(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("rmw_rd_gnt0", gnt0, 1);
    chk("rmw_rd_gnt1", gnt1, 0);
    tick();
    we0 = 1; wdata0 = rdata0 + 32'd1; lock0 = 0;
    @(negedge clk);
    chk("rmw_wr_gnt0", gnt0, 1);
    chk("rmw_wr_gnt1", gnt1, 0);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("rmw_after_gnt1", gnt1, 1);
    tick();
    addr1 = 32'h8;
    push(1, 32'd6);
    @(negedge clk);
    chk("rmw_rb_gnt1", gnt1, 1);
    tick();
    req0 = 1; we0 = 1; addr0 = 32'h80; lock0 = 1;
    we1 = 1; addr1 = 32'h84;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("lk_gnt0", gnt0, 1);
      chk("lk_gnt1", gnt1, 0);
      chk("lk_lto", lockTimeout, 0);
      tick();
    end
    @(negedge clk);
    chk("to_gnt", {gnt1, gnt0}, 0);
    chk("to_we", memWrEnable, 0);
    tick();
    @(negedge clk);
    chk("to_lto", lockTimeout, 1);
    chk("to_gnt1", gnt1, 1);
    chk("to_gnt0", gnt0, 0);
    tick();
    lock0 = 0;
    @(negedge clk);
    chk("to_lto_end", lockTimeout, 0);
    tick();
    req0 = 0; req1 = 0;
    tick();
    req0 = 1; we0 = 0; addr0 = 32'h40;
    @(negedge clk);
    chk("mr_gnt0", gnt0, 1);
    tick();
    rst = 1'b0;
    req1 = 1; we0 = 1; we1 = 1; addr0 = 32'h80; addr1 = 32'h84;
    #1;
    chk("mr_rvalid0", rvalid0, 0);
    chk("mr_we", memWrEnable, 0);
    chk("mr_gnt", {gnt1, gnt0}, 0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_tie_gnt0", gnt0, 1);
    chk("mr_tie_gnt1", gnt1, 0);
    tick();
    req0 = 0; req1 = 0;
    repeat (3) tick();
    chk("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single data memory between port 0 (core load/store unit) and port 1 (debug/loader master). It grants at most one single-beat access per cycle and drives the memory's addr/dataIn/wrEnable. It returns read data to the winning requester one cycle after grant. An optional lock lets a requester hold the memory for read-modify-write sequences, bounded by a timeout.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
MAX_LOCK_CYCLES, 16, max consecutive cycles a lock may hold ownership before forced release (range 1..255).

Ports:
clk  in  1  clock
rst  in  1  reset (details under Behaviour)
req0/req1  in  1  access request, held until granted
we0/we1  in  1  1 = write, 0 = read; qualified by req
addr0/addr1  in  DataAddrPath  byte address
wdata0/wdata1  in  DataPath  write data
lock0/lock1  in  1  keep ownership after this access
gnt0/gnt1  out  1  combinational grant; the access is accepted when req&gnt
rvalid0/rvalid1  out  1  read data valid, exactly 1 cycle after a granted read
rdata0/rdata1  out  DataPath  read data, passthrough of memDataOut
memAddr  out  DataAddrPath  to memory addr
memDataIn  out  DataPath  to memory dataIn
memWrEnable  out  1  to memory wrEnable
memDataOut  in  DataPath  from memory dataOut
lockTimeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset: rst, asynchronous, active-low; clock clk.
  - While rst=0: state=IDLE, rrPtr=port 0, lockCnt=0, pending rvalid flags cleared, lockTimeout=0.
  - gnt0/gnt1=0 and memWrEnable=0 while rst=0.
  - A read granted in the cycle before reset asserts never produces rvalid.
- Memory timing: the memory registers addr/data/we on each clk edge. Read data for a read granted in cycle t is valid on memDataOut in cycle t+1.
  - rvalidN is registered: rvalidN(t+1) = gntN&reqN&!weN at t.
  - rdataN = memDataOut unconditionally. Consumers qualify it with rvalidN.
- Memory side, combinational:
  - If a grant is active: memAddr/memDataIn/memWrEnable = granted port's addr/wdata/we.
  - Else: memAddr=0, memDataIn=0, memWrEnable=0.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: pick a winner among requesters.
    - PRIORITY_MODE=1: port 0 wins.
    - PRIORITY_MODE=0: on a tie, the port at rrPtr wins. A single requester always wins.
    - After a grant, rrPtr moves to the other port.
    - If the winner's lock=1: next state OWNk, lockCnt=1.
  - OWNk: only port k may be granted; the other port's gnt=0.
    - Granted access with lockk=1: stay in OWNk and increment lockCnt.
    - Granted access with lockk=0, or a cycle with reqk=0 and lockk=0: return to IDLE.
    - lockCnt reaching MAX_LOCK_CYCLES: forced to IDLE, lockTimeout=1 for one cycle, rrPtr set to the other port.
    - No access is granted in the forced-release cycle.
- Boundary cases:
  - Both ports idle: no grant, memory inputs zeroed; rrPtr unchanged.
  - Read immediately after a write to the same address, either port: returns new data. Arbiter adds no buffering.
  - rvalid0 and rvalid1 are never both 1.
  - Port holding req with changing addr before grant: the value at the grant cycle is used.
  - lock asserted with req=0 in IDLE: ignored.

Decomposition:
- Shared Types package:
  - enum ArbState {IDLE, OWN0, OWN1}
  - enum ArbPortSel {ARB_PORT0, ARB_PORT1}
  - constant ARB_LOCK_CNT_WIDTH=8
- Reuse existing DataPath/DataAddrPath.
- One sub-module, dmem_arb_pick: combinational winner select from (req0, req1, rrPtr, PRIORITY_MODE, state) -> grant vector.
- Counter, FSM, rvalid pipeline and muxes live in dmem_arbiter.

Test Plan:
- Single read: memory word 0x10 = 0xDEADBEEF; req1 read addr 0x40 -> gnt1 same cycle, rvalid1=1 and rdata1=0xDEADBEEF next cycle, rvalid0=0.
- Round-robin tie: PRIORITY_MODE=0, req0 and req1 held for 4 cycles from reset -> grants 0,1,0,1.
- Fixed priority: PRIORITY_MODE=1 with the same stimulus -> gnt0 every cycle, gnt1 never.
- Lock and timeout: port 0 locks an RMW (read 0x8, write 0x8 = read+1) while req1 pending -> gnt1 only after the unlocked write. A separate case holds lock0 -> lockTimeout pulse after 16 cycles, then gnt1.
- Write then read back: port 0 writes 0x12345678 to 0x20, port 1 reads 0x20 next cycle -> rdata1=0x12345678.
- Reset mid-operation: rst=0 in the cycle after a granted read -> rvalid0=0, memWrEnable=0, state=IDLE immediately. After release the first tie goes to port 0.
